ecc_scrubber: RTL and testbench
===============================

ECC_SCRUBBER -- requirements
Module: ecc_scrubber

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width.
REQ-002 Parameter NUM_WORDS, default 16, words scrubbed per pass (2..2^ADDR_W).
REQ-003 Parameter INTERVAL, default 64, idle cycles between passes in periodic mode (>=1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 scrub_en  input  1  periodic scrubbing enabled.
REQ-007 scrub_start  input  1  single-cycle pulse; request one pass now.
REQ-008 mem_busy  input  1  functional port owns memory this cycle; scrubber must not issue.
REQ-009 mem_rdata  input  13  codeword returned one cycle after mem_rd_en.
REQ-010 mem_addr  output  ADDR_W  scrub address.
REQ-011 mem_rd_en  output  1  read strobe.
REQ-012 mem_wr_en  output  1  write-back strobe.
REQ-013 mem_wdata  output  13  corrected codeword.
REQ-014 busy  output  1  high whenever a pass is in progress.
REQ-015 pass_done  output  1  one-cycle pulse at end of pass.
REQ-016 corr_count  output  8  corrected-error count, saturating at 255.
REQ-017 uncorr_count  output  8  uncorrectable-error count, saturating at 255.
REQ-018 err_irq  output  1  one-cycle pulse per uncorrectable word.
REQ-019 last_err_addr  output  ADDR_W  address of most recent uncorrectable word.

Function
REQ-020 Codeword: bit 0 = overall parity (XOR of bits 1..12); bits 1..12 = Hamming positions 1..12; check bits at 1,2,4,8; data d0..d7 at 3,5,6,7,9,10,11,12.
REQ-021 States: IDLE, READ, CHECK, WRITE, NEXT.
REQ-022 IDLE: interval counter counts up while scrub_en=1; pass starts when it reaches INTERVAL-1 or on scrub_start; counter clears on pass start and holds at 0 while scrub_en=0.
REQ-023 READ: mem_rd_en=1 for exactly one cycle, only in a cycle with mem_busy=0; stall in READ while mem_busy=1; go to CHECK.
REQ-024 CHECK: decode mem_rdata; syndrome s = XOR of positions of set bits 1..12; p = XOR of bits 0..12.
REQ-025 s=0,p=0: clean, go to NEXT, no write.
REQ-026 s in 1..12, p=1: flip bit s, go to WRITE; s=0, p=1: flip bit 0, go to WRITE.
REQ-027 s!=0,p=0, or s in 13..15 with p=1: uncorrectable; increment uncorr_count, pulse err_irq, load last_err_addr, go to NEXT, no write.
REQ-028 WRITE: mem_wr_en=1 for one cycle with mem_busy=0, mem_wdata = corrected codeword, mem_addr unchanged; stall while mem_busy=1; increment corr_count on the strobe cycle; go to NEXT.
REQ-029 NEXT: if mem_addr=NUM_WORDS-1, mem_addr wraps to 0, pass_done pulses, go to IDLE; else mem_addr+1, go to READ.
REQ-030 mem_rd_en and mem_wr_en never both high; neither high while mem_busy=1.
REQ-031 scrub_start while busy=1 is ignored; scrub_start and interval expiry in the same cycle start one pass.
REQ-032 scrub_en deassert mid-pass: current pass completes.
REQ-033 Counters hold at 255; no wrap.
REQ-034 Clean-word latency, mem_busy=0: READ to next READ = 3 cycles; corrected word = 4 cycles.

Reset
REQ-035 rst=1 at a clock edge: state IDLE, mem_addr=0, interval counter=0, all strobes/pulses=0, busy=0, corr_count=0, uncorr_count=0, last_err_addr=0, mem_wdata=0.
REQ-036 Reset mid-pass aborts immediately; no write-back is issued after reset, including a pending one in WRITE.

Verification
REQ-037 16 clean codewords, scrub_start pulse -> 16 reads at addr 0..15, no writes, pass_done once, both counters 0.
REQ-038 Addr 3 holds encoding of 0xA5 with bit 5 flipped -> one write to addr 3 of clean 0xA5 codeword, corr_count=1; second pass shows no write.
REQ-039 Addr 7 holds 0x3C codeword with bits 2 and 9 flipped -> no write, uncorr_count=1, err_irq one pulse, last_err_addr=7.
REQ-040 mem_busy held high 5 cycles during READ and during WRITE -> strobes delayed until mem_busy=0, never asserted with mem_busy=1.
REQ-041 scrub_en=1, INTERVAL=64, clean memory -> passes start 64 cycles after each pass_done; scrub_start during a pass has no effect.
REQ-042 rst asserted in WRITE state -> no mem_wr_en, all outputs at reset values next cycle.

Source files
------------

// File: rtl/ecc_scrubber.sv
// ---------------------------------------------------------------------------
// ecc_scrubber
//   Background scrubber for a small memory protected by a 13-bit extended
//   Hamming code (SEC-DED over 8 data bits). Each pass walks addresses
//   0..NUM_WORDS-1. For each word it reads the codeword, decodes it, and
//   writes back the corrected codeword when a single-bit error is found.
//   Uncorrectable (double) errors are counted and reported, and the word is
//   left as it is. Passes are started by a scrub_start pulse, or
//   periodically after INTERVAL idle cycles while scrub_en is high. The
//   scrubber only touches memory in cycles where the functional port leaves
//   it free (mem_busy=0).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   scrub_en       enable periodic passes
//   scrub_start    one-cycle request for a pass (ignored while busy)
//   mem_busy       functional port owns the memory this cycle
//   mem_rdata      codeword, valid the cycle after mem_rd_en
//   mem_addr       scrub address
//   mem_rd_en      read strobe
//   mem_wr_en      write-back strobe
//   mem_wdata      corrected codeword for write-back
//   busy           pass in progress
//   pass_done      one-cycle pulse as the last word of a pass retires
//   corr_count     corrected-error count, saturating at 255
//   uncorr_count   uncorrectable-error count, saturating at 255
//   err_irq        one-cycle pulse per uncorrectable word
//   last_err_addr  address of the most recent uncorrectable word
// ---------------------------------------------------------------------------
module ecc_scrubber #(
  parameter int ADDR_W    = 4,
  parameter int NUM_WORDS = 16,
  parameter int INTERVAL  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scrub_en,
  input  logic              scrub_start,
  input  logic              mem_busy,
  input  logic [12:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [12:0]       mem_wdata,
  output logic              busy,
  output logic              pass_done,
  output logic [7:0]        corr_count,
  output logic [7:0]        uncorr_count,
  output logic              err_irq,
  output logic [ADDR_W-1:0] last_err_addr
);

  localparam int                CNT_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_NEXT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [12:0]         wdata_q, wdata_d;
  logic [7:0]          corr_q, corr_d;
  logic [7:0]          uncorr_q, uncorr_d;
  logic [ADDR_W-1:0]   last_q, last_d;

  logic                rd_strobe, wr_strobe, done_pulse, irq_pulse;

  // -------------------------------------------------------------------------
  // Decoder. The syndrome is the XOR of the positions of all set bits 1..12.
  // The overall parity covers bits 0..12, so a single flip anywhere makes it
  // odd. Odd parity with syndrome 0 means bit 0 itself flipped. Even parity
  // with a non-zero syndrome is a double error. Odd parity pointing past
  // position 12 can't be a single error either.
  // -------------------------------------------------------------------------
  logic [3:0]  syndrome;
  logic        parity;
  logic [12:0] corrected;
  logic        fixable;
  logic        uncorrectable;

  // NOTE: every signal written in an always_comb gets a default value first.
  // Without it, a path that skips an assignment would infer a latch.
  always_comb begin
    syndrome      = '0;
    fixable       = 1'b0;
    uncorrectable = 1'b0;
    for (int i = 1; i < 13; i++) begin
      if (mem_rdata[i]) syndrome = syndrome ^ 4'(i);
    end
    parity    = ^mem_rdata;
    // A zero syndrome selects bit 0, which is exactly the overall-parity fix.
    corrected = mem_rdata ^ (13'd1 << syndrome);
    if (parity) begin
      if (syndrome <= 4'd12) fixable       = 1'b1;
      else                   uncorrectable = 1'b1;
    end else if (syndrome != 4'd0) begin
      uncorrectable = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and strobe logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    last_d     = last_q;
    rd_strobe  = 1'b0;
    wr_strobe  = 1'b0;
    done_pulse = 1'b0;
    irq_pulse  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A start request and interval expiry in the same cycle give one pass.
        if (scrub_start || (scrub_en && (cnt_q == CNT_LAST))) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else if (scrub_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end

      S_READ: begin
        if (!mem_busy) begin
          rd_strobe = 1'b1;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        if (fixable) begin
          wdata_d = corrected;
          state_d = S_WRITE;
        end else if (uncorrectable) begin
          irq_pulse = 1'b1;
          last_d    = addr_q;
          if (uncorr_q != 8'hFF) uncorr_d = uncorr_q + 8'd1;
          state_d   = S_NEXT;
        end else begin
          state_d = S_NEXT;
        end
      end

      S_WRITE: begin
        if (!mem_busy) begin
          wr_strobe = 1'b1;
          if (corr_q != 8'hFF) corr_d = corr_q + 8'd1;
          state_d   = S_NEXT;
        end
      end

      S_NEXT: begin
        if (addr_q == ADDR_LAST) begin
          addr_d     = '0;
          done_pulse = 1'b1;
          state_d    = S_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: registers are updated with non-blocking assignments. Then every
  // flop samples the values from before the edge, whatever order the
  // statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      last_q   <= last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The strobes and pulses are masked by rst. A reset that lands
  // while a write-back is pending must not let that write reach the memory
  // in the same cycle.
  // -------------------------------------------------------------------------
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_rd_en     = rd_strobe  & ~rst;
  assign mem_wr_en     = wr_strobe  & ~rst;
  assign pass_done     = done_pulse & ~rst;
  assign err_irq       = irq_pulse  & ~rst;
  assign busy          = (state_q != S_IDLE);
  assign corr_count    = corr_q;
  assign uncorr_count  = uncorr_q;
  assign last_err_addr = last_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// ---------------------------------------------------------------------------
// tb_ecc_scrubber
//   Scoreboard bench for ecc_scrubber. The reference model knows which bits
//   were flipped in each stored word. From that it predicts, per address, a
//   read, then a write of the clean codeword (one flip) or an irq (two
//   flips), then pass_done with the expected counter values. A monitor pops
//   and compares whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_ecc_scrubber;
  localparam int AW = 4;
  localparam int NW = 16;
  localparam int IV = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, scrub_en, scrub_start, mem_busy;
  logic [12:0]   mem_rdata;
  logic [AW-1:0] mem_addr, last_err_addr;
  logic          mem_rd_en, mem_wr_en, busy, pass_done, err_irq;
  logic [12:0]   mem_wdata;
  logic [7:0]    corr_count, uncorr_count;

  ecc_scrubber #(.ADDR_W(AW), .NUM_WORDS(NW), .INTERVAL(IV)) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_start(scrub_start),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .busy(busy), .pass_done(pass_done), .corr_count(corr_count),
    .uncorr_count(uncorr_count), .err_irq(err_irq), .last_err_addr(last_err_addr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: one-cycle read latency. Outside read cycles it returns garbage,
  // so a decode of the wrong cycle shows up.
  logic [12:0] mem [NW];
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [12:0] bd_data;
  always @(posedge clk) begin
    if (bd_we)          mem[bd_addr]  <= bd_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd_en ? mem[mem_addr] : 13'($urandom);
  end

  // ---------------- reference model ----------------
  typedef enum int {EV_RD, EV_WR, EV_IRQ, EV_DONE} kind_e;
  typedef struct {
    kind_e       kind;
    int          addr;
    logic [12:0] data;
    int          gap;
    int          corr;
    int          uncorr;
    int          last;
  } ev_t;
  ev_t sb[$];

  logic [7:0]  m_data [NW];
  logic [12:0] m_mask [NW];
  int m_corr = 0, m_uncorr = 0, m_last = 0;

  // Encoder: data at 3,5,6,7,9,10,11,12. Check bit 2^c covers the positions
  // with bit c set. Bit 0 makes the whole word even parity.
  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:0] w;
    int dpos [8];
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
    w = '0;
    for (int k = 0; k < 8; k++) w[dpos[k]] = d[k];
    for (int c = 0; c < 4; c++)
      for (int i = 1; i < 13; i++)
        if (((i >> c) & 1) == 1 && i != (1 << c)) w[1 << c] = w[1 << c] ^ w[i];
    w[0] = ^w[12:1];
    return w;
  endfunction

  function automatic logic [12:0] rand_mask(input int nflips);
    logic [12:0] m;
    m = '0;
    while ($countones(m) < nflips) m[$urandom_range(0, 12)] = 1'b1;
    return m;
  endfunction

  // Expected events of one pass; first_gap is the read-0 distance from the
  // previous pass_done (0 = not checked).
  task automatic push_pass(input int first_gap);
    ev_t e;
    int  next_gap;
    next_gap = first_gap;
    for (int a = 0; a < NW; a++) begin
      e = '{kind: EV_RD, addr: a, data: '0, gap: next_gap, corr: 0, uncorr: 0, last: 0};
      sb.push_back(e);
      next_gap = 3;
      if ($countones(m_mask[a]) == 1) begin
        e.kind = EV_WR; e.data = enc(m_data[a]);
        sb.push_back(e);
        m_mask[a] = '0;
        if (m_corr < 255) m_corr++;
        next_gap = 4;
      end else if ($countones(m_mask[a]) == 2) begin
        e.kind = EV_IRQ;
        sb.push_back(e);
        if (m_uncorr < 255) m_uncorr++;
        m_last = a;
      end
    end
    e = '{kind: EV_DONE, addr: 0, data: '0, gap: 0, corr: m_corr, uncorr: m_uncorr, last: m_last};
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int ref_cyc = 0, done_cnt = 0, irq_cnt = 0;
  bit busy_seen = 1'b1;

  task automatic take(input kind_e k, output ev_t e, output bit ok);
    ok = 1'b0;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", k, $time);
    end else begin
      e = sb.pop_front();
      check("event_kind", e.kind, k);
      ok = (e.kind == k);
    end
  endtask

  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_rd_en", 32'(mem_rd_en), 0);
        check("rst_wr_en", 32'(mem_wr_en), 0);
        busy_seen = 1'b1;
      end else begin
        if (mem_rd_en || mem_wr_en) begin
          check("strobe_overlap", 32'(mem_rd_en & mem_wr_en), 0);
          check("strobe_while_busy", 32'(mem_busy), 0);
        end
        if (mem_rd_en) begin
          take(EV_RD, e, ok);
          if (ok) begin
            check("rd_addr", 32'(mem_addr), e.addr);
            if (e.gap != 0 && !busy_seen) check("rd_gap", cyc - ref_cyc, e.gap);
          end
          ref_cyc = cyc; busy_seen = 1'b0;
        end
        if (mem_wr_en) begin
          take(EV_WR, e, ok);
          if (ok) begin
            check("wr_addr", 32'(mem_addr), e.addr);
            check("wr_data", 32'(mem_wdata), 32'(e.data));
          end
        end
        if (err_irq) begin
          irq_cnt++;
          take(EV_IRQ, e, ok);
          if (ok) check("irq_addr", 32'(mem_addr), e.addr);
        end
        if (pass_done) begin
          done_cnt++;
          take(EV_DONE, e, ok);
          if (ok) begin
            check("corr_count", 32'(corr_count), e.corr);
            check("uncorr_count", 32'(uncorr_count), e.uncorr);
            check("last_err_addr", 32'(last_err_addr), e.last);
          end
          ref_cyc = cyc; busy_seen = 1'b0;
        end
        if (mem_busy) busy_seen = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_busy = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_busy) mem_busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic load_word(input int a, input logic [7:0] d, input logic [12:0] mask);
    m_data[a] = d; m_mask[a] = mask;
    bd_we = 1'b1; bd_addr = 4'(a); bd_data = enc(d) ^ mask;
    tick();
    bd_we = 1'b0;
  endtask

  // mode 0: all clean; 1: 0..2 random flips; 2: low half 1 flip, high half 2
  task automatic load_all(input int mode);
    int n;
    for (int a = 0; a < NW; a++) begin
      n = (mode == 0) ? 0 : (mode == 1) ? $urandom_range(0, 2) : (a < NW / 2) ? 1 : 2;
      load_word(a, 8'($urandom), rand_mask(n));
    end
  endtask

  task automatic start_pass();
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 1);
    if (n >= budget) sb.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    check({tag, "_wr_en"}, 32'(mem_wr_en), 0);
    check({tag, "_pass_done"}, 32'(pass_done), 0);
    check({tag, "_err_irq"}, 32'(err_irq), 0);
    check({tag, "_corr"}, 32'(corr_count), 0);
    check({tag, "_uncorr"}, 32'(uncorr_count), 0);
    check({tag, "_last_err"}, 32'(last_err_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    int n, d0, i0;
    ev_t e;
    rst = 1'b1; scrub_en = 1'b0; scrub_start = 1'b0; mem_busy = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset("por");

    // Clean memory: 16 reads, no writes, counters stay 0.
    load_all(0);
    push_pass(0); start_pass(); wait_drain(2000);

    // Single flip at addr 3, corrected once, then a clean re-scrub.
    load_word(3, 8'hA5, 13'h0020);
    push_pass(0); start_pass(); wait_drain(2000);
    check("fixed_word_3", 32'(mem[3]), 32'(enc(8'hA5)));
    push_pass(0); start_pass(); wait_drain(2000);

    // Double flip at addr 7: reported, not written.
    load_word(7, 8'h3C, 13'h0204);
    i0 = irq_cnt;
    push_pass(0); start_pass(); wait_drain(2000);
    check("irq_pulses", irq_cnt - i0, 1);
    check("uncorr_after_double", 32'(uncorr_count), 1);
    check("last_err_is_7", 32'(last_err_addr), 7);
    check("double_word_kept", 32'(mem[7]), 32'(enc(8'h3C) ^ 13'h0204));

    // mem_busy held 5 cycles over READ: read issues on the first free cycle.
    load_all(0);
    push_pass(0);
    mem_busy = 1'b1;
    start_pass();
    repeat (4) tick();
    tick(); mem_busy = 1'b0;
    @(negedge clk);
    check("rd_after_busy", 32'(mem_rd_en), 1);
    wait_drain(2000);

    // mem_busy held 5 cycles over WRITE.
    load_word(0, 8'($urandom), rand_mask(1));
    push_pass(0);
    start_pass();
    tick(); tick(); mem_busy = 1'b1;
    repeat (4) tick();
    tick(); mem_busy = 1'b0;
    @(negedge clk);
    check("wr_after_busy", 32'(mem_wr_en), 1);
    wait_drain(2000);

    // Random contents with random mem_busy.
    rand_busy = 1'b1;
    for (int p = 0; p < 6; p++) begin
      load_all(1);
      push_pass(0); start_pass(); wait_drain(4000);
    end
    rand_busy = 1'b0; mem_busy = 1'b0;

    // Periodic mode: INTERVAL idle cycles between passes; a mid-pass
    // scrub_start changes nothing.
    load_all(0);
    push_pass(0); push_pass(IV + 1); push_pass(IV + 1);
    scrub_en = 1'b1;
    n = 0;
    while (!busy && n < 500) begin tick(); n++; end
    check("periodic_started", 32'(busy), 1);
    repeat (5) tick();
    start_pass();
    wait_drain(3000);
    scrub_en = 1'b0;

    // scrub_en dropped mid-pass: that pass completes, no further pass.
    push_pass(0);
    scrub_en = 1'b1;
    start_pass();
    repeat (10) tick();
    scrub_en = 1'b0;
    wait_drain(2000);
    d0 = done_cnt;
    repeat (150) tick();
    check("no_pass_after_disable", done_cnt, d0);

    // Saturation of both counters.
    for (int p = 0; p < 33; p++) begin
      load_all(2);
      push_pass(0); start_pass(); wait_drain(2000);
    end
    check("corr_saturated", 32'(corr_count), 255);
    check("uncorr_saturated", 32'(uncorr_count), 255);

    // Reset while a write-back is pending.
    load_word(0, 8'($urandom), rand_mask(1));
    e = '{kind: EV_RD, addr: 0, data: '0, gap: 0, corr: 0, uncorr: 0, last: 0};
    sb.push_back(e);
    start_pass();
    tick(); tick(); rst = 1'b1;
    @(negedge clk);
    check("no_wr_in_reset", 32'(mem_wr_en), 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check_reset("wr_rst");
    check("pending_write_dropped", 32'(mem[0]), 32'(enc(m_data[0]) ^ m_mask[0]));
    sb.delete();
    m_corr = 0; m_uncorr = 0; m_last = 0;

    // Recovery pass after reset.
    push_pass(0); start_pass(); wait_drain(2000);
    for (int a = 0; a < NW; a++)
      check("final_mem", 32'(mem[a]), 32'(enc(m_data[a]) ^ m_mask[a]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
